// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm_sequencer block: default sequence length,
// sequence state codes and the controller-state encoding.
package fsm_seq_pkg;

    localparam int NUM_STATES_DEF = 10;

    localparam logic [3:0] Q0 = 4'd0;
    localparam logic [3:0] Q1 = 4'd1;
    localparam logic [3:0] Q2 = 4'd2;
    localparam logic [3:0] Q3 = 4'd3;
    localparam logic [3:0] Q4 = 4'd4;
    localparam logic [3:0] Q5 = 4'd5;
    localparam logic [3:0] Q6 = 4'd6;
    localparam logic [3:0] Q7 = 4'd7;
    localparam logic [3:0] Q8 = 4'd8;
    localparam logic [3:0] Q9 = 4'd9;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_DONE = 2'd2
    } ctrl_t;

endpackage

// File: rtl/fsm_seq_dwell_regfile.sv
// Per-state dwell table: one write port, one combinational read port.
// Entries beyond NUM_STATES are never written and stay at 1.
module fsm_seq_dwell_regfile #(
    parameter int NUM_STATES = 10,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic [DWELL_W-1:0] wdata,
    input  logic [3:0]         raddr,
    output logic [DWELL_W-1:0] rdata
);

    logic [DWELL_W-1:0] mem [16];

    // Table storage; out-of-range writes fall through without effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= DWELL_W'(1);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (we && (waddr == 4'(i)) && (i < NUM_STATES)) mem[i] <= wdata;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_sequencer.sv
// Timed state sequencer: steps Q0..Q(NUM_STATES-1), each for its dwell count.
// Optional feature: define FSM_SEQUENCER_LOOP_EN to add the 'loop' input,
// which wraps the last state straight back to Q0 instead of finishing.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
`ifdef FSM_SEQUENCER_LOOP_EN
    input  logic               loop,
`endif
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [DWELL_W-1:0] cfg_data,
    output logic [3:0]         state,
    output logic               state_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] LAST = 4'(NUM_STATES - 1);

    ctrl_t              ctrl, ctrl_nxt;
    logic [3:0]         cur, cur_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [3:0]         raddr;
    logic [DWELL_W-1:0] rdata;
    logic               wrap;
    logic               expired;

`ifdef FSM_SEQUENCER_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    // A loaded count of 0 or 1 both mean a single cycle in the state.
    assign expired = (cnt <= DWELL_W'(1));

    fsm_seq_dwell_regfile #(
        .NUM_STATES(NUM_STATES),
        .DWELL_W   (DWELL_W)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr(raddr),
        .rdata(rdata)
    );

    // Read the dwell of whichever state would be entered next.
    always_comb begin
        raddr = Q0;
        if (ctrl == CTRL_RUN && cur != LAST) raddr = cur + 4'd1;
    end

    // Controller state, sequence step and countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= CTRL_IDLE;
            cur  <= Q0;
            cnt  <= '0;
        end else begin
            ctrl <= ctrl_nxt;
            cur  <= cur_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Next-state logic: abort wins, then hold, then expiry.
    always_comb begin
        ctrl_nxt = ctrl;
        cur_nxt  = cur;
        cnt_nxt  = cnt;
        case (ctrl)
            CTRL_IDLE: begin
                if (start) begin
                    ctrl_nxt = CTRL_RUN;
                    cur_nxt  = Q0;
                    cnt_nxt  = rdata;
                end
            end
            CTRL_RUN: begin
                if (abort) begin
                    ctrl_nxt = CTRL_IDLE;
                    cur_nxt  = Q0;
                    cnt_nxt  = '0;
                end else if (!hold) begin
                    if (!expired) begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end else if (cur != LAST) begin
                        cur_nxt = cur + 4'd1;
                        cnt_nxt = rdata;
                    end else if (wrap) begin
                        cur_nxt = Q0;
                        cnt_nxt = rdata;
                    end else begin
                        ctrl_nxt = CTRL_DONE;
                        cur_nxt  = Q0;
                        cnt_nxt  = '0;
                    end
                end
            end
            CTRL_DONE: begin
                ctrl_nxt = CTRL_IDLE;
                cur_nxt  = Q0;
                cnt_nxt  = '0;
            end
            default: begin
                ctrl_nxt = CTRL_IDLE;
                cur_nxt  = Q0;
                cnt_nxt  = '0;
            end
        endcase
    end

    assign state       = cur;
    assign state_valid = (ctrl == CTRL_RUN);
    assign busy        = (ctrl != CTRL_IDLE);
    assign done        = (ctrl == CTRL_DONE);

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: event-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fsm_sequencer;

    localparam int NS = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          hold = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = 4'd0;
    logic [DW-1:0] cfg_data = '0;
    logic [3:0]    state;
    logic          state_valid;
    logic          busy;
    logic          done;
`ifdef FSM_SEQUENCER_LOOP_EN
    logic          loop = 1'b0;
`endif

    int ntests = 0;
    int nfail  = 0;
    int nprint = 0;

    fsm_sequencer #(.NUM_STATES(NS), .DWELL_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
`ifdef FSM_SEQUENCER_LOOP_EN
        .loop       (loop),
`endif
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .state      (state),
        .state_valid(state_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: step index (-1 idle, NS = done cycle), time spent in
    // the step versus its allotted length, and a mirror of the dwell table.
    int mk = -1;
    int len = 0;
    int el = 0;
    int tab [16];

    function automatic int fix1(int v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = -1; len = 0; el = 0;
            for (int i = 0; i < 16; i++) tab[i] = 1;
        end else begin
            if (mk == -1) begin
                if (start) begin mk = 0; len = fix1(tab[0]); el = 0; end
            end else if (mk == NS) begin
                mk = -1;
            end else if (abort) begin
                mk = -1;
            end else if (!hold) begin
                el = el + 1;
                if (el >= len) begin
                    if (mk == NS - 1) begin
`ifdef FSM_SEQUENCER_LOOP_EN
                        if (loop) begin mk = 0; len = fix1(tab[0]); el = 0; end
                        else mk = NS;
`else
                        mk = NS;
`endif
                    end else begin
                        mk = mk + 1; len = fix1(tab[mk]); el = 0;
                    end
                end
            end
            if (cfg_we && int'(cfg_addr) < NS) tab[cfg_addr] = int'(cfg_data);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus visibility/done monitors.
    int vis [16];
    bit vis_clear = 1'b0;
    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        int es; bit ev, eb, ed;
        es = (mk >= 0 && mk < NS) ? mk : 0;
        ev = (mk >= 0 && mk < NS);
        eb = (mk != -1);
        ed = (mk == NS);
        ntests++;
        if (int'(state) != es || state_valid !== ev || busy !== eb || done !== ed) begin
            nfail++;
            if (nprint < 20) begin
                nprint++;
                $display("FAIL cycle_cmp t=%0t: state/valid/busy/done got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         $time, state, state_valid, busy, done, es, ev, eb, ed);
            end
        end
        if (vis_clear) begin
            for (int i = 0; i < 16; i++) vis[i] = 0;
        end
        if (state_valid === 1'b1) vis[state] = vis[state] + 1;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = DW'(d);
        step(1);
        cfg_we = 1'b0;
    endtask

    int t0 = 0;
    task automatic start_run();
        vis_clear = 1'b1;
        @(negedge clk); #1;
        vis_clear = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_state(input int k);
        int n = 0;
        while (!(state_valid && int'(state) == k) && n < 200) begin step(1); n++; end
        if (n >= 200) chk("wait_state_timeout", n, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin step(1); n++; end
        if (n >= 500) chk("wait_idle_timeout", n, 0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 16; i++) vis[i] = 0;
        #1 rst = 1'b1;
        step(3);
        chk("reset_state", int'(state), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(state_valid), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        step(2);

        // Dwell {3,1,...,1}: done 12 cycles after the start edge.
        cfg(0, 3);
        start_run();
        wait_idle();
        chk("q0_len", vis[0], 3);
        chk("q1_len", vis[1], 1);
        chk("q9_len", vis[9], 1);
        chk("done_latency", done_cyc - t0, 12);

        // Dwell 0 behaves as 1.
        cfg(4, 0);
        start_run();
        wait_idle();
        chk("q4_zero_dwell", vis[4], 1);
        chk("done_latency_z", done_cyc - t0, 12);

        // Hold for 5 cycles in Q2 with dwell 4.
        cfg(2, 4);
        start_run();
        wait_state(2);
        hold = 1'b1;
        step(5);
        hold = 1'b0;
        wait_idle();
        chk("q2_hold_len", vis[2], 9);

        // Abort and start together in Q6.
        dc = done_cnt;
        start_run();
        wait_state(6);
        abort = 1'b1; start = 1'b1;
        step(1);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(state_valid), 0);
        step(1);
        chk("abort_no_restart", int'(busy), 0);
        chk("abort_no_done", done_cnt, dc);

        // Writing the executing state's dwell only affects the next entry.
        cfg(3, 2);
        start_run();
        wait_state(3);
        cfg(3, 7);
        cfg(12, 5);
        wait_idle();
        chk("q3_old_len", vis[3], 2);
        start_run();
        wait_idle();
        chk("q3_new_len", vis[3], 7);
        chk("q4_after_oor", vis[4], 1);
        chk("done_latency_mix", done_cyc - t0, 21);

        // Asynchronous reset mid-Q5.
        start_run();
        wait_state(5);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(state_valid), 0);
        step(2);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", int'(busy), 0);
        start_run();
        wait_idle();
        chk("post_rst_q0", vis[0], 1);
        chk("post_rst_q3", vis[3], 1);
        chk("post_rst_latency", done_cyc - t0, 10);

`ifdef FSM_SEQUENCER_LOOP_EN
        dc = done_cnt;
        loop = 1'b1;
        start_run();
        step(40);
        chk("loop_no_done", done_cnt, dc);
        chk("loop_busy", int'(busy), 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        loop = 1'b0;
        chk("loop_abort", int'(busy), 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom % 4) == 0;
            abort    = ($urandom % 23) == 0;
            hold     = ($urandom % 5) == 0;
            cfg_we   = ($urandom % 6) == 0;
            cfg_addr = 4'($urandom % 16);
            cfg_data = DW'($urandom % 5);
`ifdef FSM_SEQUENCER_LOOP_EN
            loop     = ($urandom % 3) == 0;
`endif
            step(1);
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0; cfg_we = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fsm_sequencer.md
FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 SHALL have parameter NUM_STATES, default 10, number of sequence states Q0..Q(NUM_STATES-1); legal range 2..16.
REQ-002 SHALL have parameter DWELL_W, default 16, width of each per-state dwell value in clock cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a sequence; accepted only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the running sequence.
REQ-007 SHALL have port hold  input  1  freeze the dwell countdown while high.
REQ-008 SHALL have port cfg_we  input  1  dwell-table write strobe.
REQ-009 SHALL have port cfg_addr  input  4  dwell-table index.
REQ-010 SHALL have port cfg_data  input  DWELL_W  dwell value to write.
REQ-011 SHALL have port state  output  4  current sequence state code, Qk = k.
REQ-012 SHALL have port state_valid  output  1  high while state drives a live sequence step.
REQ-013 SHALL have port busy  output  1  high from start acceptance until return to IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-015 SHALL implement controller states IDLE, RUN, DONE; HOLD is a qualifier on RUN, not a separate state.
REQ-016 SHALL, on start=1 in IDLE at edge t, present state=0, state_valid=1, busy=1 after edge t and load the countdown with dwell[0].
REQ-017 SHALL keep each Qk for exactly max(dwell[k],1) cycles with hold=0; dwell 0 is treated as 1.
REQ-018 SHALL advance Qk -> Qk+1 on the edge where the countdown expires and load dwell[k+1] on that same edge.
REQ-019 SHALL, on expiry of Q(NUM_STATES-1), enter DONE for one cycle: done=1, state_valid=0, busy=1, state=0; then enter IDLE with busy=0.
REQ-020 SHALL, while hold=1 in RUN, freeze both the countdown and state; remaining dwell resumes unchanged when hold falls.
REQ-021 SHALL give abort priority over start, hold and expiry: in RUN or DONE, abort=1 at edge t yields IDLE, state=0, state_valid=0, busy=0, done=0 after edge t.
REQ-022 SHALL ignore start when not in IDLE, and ignore abort in IDLE.
REQ-023 SHALL write cfg_data to dwell[cfg_addr] when cfg_we=1 and cfg_addr<NUM_STATES; out-of-range writes are dropped.
REQ-024 SHALL let a cfg write to the currently executing state take effect only on that state's next entry; a loaded countdown is never altered.
REQ-025 SHALL accept cfg writes in every controller state, including the cycle start is accepted; if cfg_addr=0 in that cycle, dwell[0] loads the old value.

Reset
REQ-026 SHALL, while rst=1, force IDLE, state=0, state_valid=0, busy=0, done=0, countdown=0, and all dwell entries to 1.
REQ-027 SHALL, after rst falls mid-sequence, remain in IDLE until a new start.

Configuration
REQ-028 SHALL support macro FSM_SEQUENCER_LOOP_EN: when defined, add input loop (1 bit) that, if high at Q(NUM_STATES-1) expiry, makes the sequence wrap directly to Q0 with no DONE cycle and no done pulse; abort still ends the loop.
REQ-029 SHALL, without FSM_SEQUENCER_LOOP_EN, have no loop port and always terminate via DONE as in REQ-019.

Structure
REQ-030 SHALL take NUM_STATES default, the Q0..Q9 state codes and the controller-state encoding from shared package fsm_seq_pkg.
REQ-031 SHALL hold the dwell table in one sub-module, fsm_seq_dwell_regfile (write port plus one combinational read port indexed by next state).

Verification
REQ-032 SHALL cover: dwell={3,1,...,1}, start pulse -> Q0 for 3 cycles, Q1..Q9 for 1 cycle each, done exactly 12 cycles after start edge.
REQ-033 SHALL cover: dwell[4]=0 -> Q4 held exactly 1 cycle.
REQ-034 SHALL cover: hold high 5 cycles mid-Q2 (dwell[2]=4) -> Q2 visible exactly 9 cycles.
REQ-035 SHALL cover: abort and start asserted together in Q6 -> IDLE next cycle, busy=0, no done, start not reaccepted that edge.
REQ-036 SHALL cover: cfg write dwell[3]=7 while in Q3 (loaded 2) -> Q3 lasts 2 cycles now, 7 cycles on the next run; cfg_addr=12 write leaves table unchanged.
REQ-037 SHALL cover: rst asserted mid-Q5 -> outputs zero immediately without clk edge; with FSM_SEQUENCER_LOOP_EN and loop=1, Q9 -> Q0 with done never asserted.
